// File: rtl/mca_decimation_sequencer.sv
// mca_decimation_sequencer: sequences the multi-clock-adder FIR datapath of the downsampling estimator
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   enable              : gates acceptance of new control words (in-flight computation still completes)
//   in_valid/in_ready   : control-word handshake, in_data passed to the S window as s_data
//   s_shift_en, s_data  : shift strobe and data for the external S window register
//   mca_start           : one-cycle start pulse to the adder tree
//   mca_sample          : adder result, captured MCA_LATENCY cycles after mca_start
//   out_valid/out_ready : one-entry output register handshake carrying out_sample
//   busy                : a computation is being started or awaited
//   overrun             : sticky, an unconsumed sample was overwritten
module mca_decimation_sequencer #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int M = 4,
  parameter int PRIME_INPUTS = 64,
  parameter int DOWNSAMPLE = 4,
  parameter int MCA_LATENCY = 34
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [M-1:0]                        in_data,
  output logic                                s_shift_en,
  output logic [M-1:0]                        s_data,
  output logic                                mca_start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] mca_sample,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
  output logic                                busy,
  output logic                                overrun
);
  localparam int ACC_MAX = (PRIME_INPUTS > DOWNSAMPLE) ? PRIME_INPUTS : DOWNSAMPLE;
  localparam int AW = $clog2(ACC_MAX + 1);
  localparam int LW = $clog2(MCA_LATENCY + 1);
  localparam logic [AW-1:0] PRIME_LAST = AW'(PRIME_INPUTS - 1);
  localparam logic [AW-1:0] DS_LAST = AW'(DOWNSAMPLE - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MCA_LATENCY - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
  state_t                              r_state;
  logic                                r_primed;
  logic [AW-1:0]                       r_acc_cnt;
  logic [LW-1:0]                       r_lat_cnt;
  logic                                r_out_valid;
  logic signed [WIDTH_COEFFICIENT-1:0] r_out_sample;
  logic                                r_overrun;
  logic                                w_accept;
  logic                                w_wrap;
  logic                                w_capture;
  assign in_ready   = (r_state == S_IDLE) & enable & ~rst;
  assign w_accept   = in_valid & in_ready;
  assign s_shift_en = w_accept;
  assign s_data     = in_data;
  assign mca_start  = (r_state == S_START) & ~rst;
  assign busy       = (r_state != S_IDLE) & ~rst;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign overrun    = r_overrun;
  // Priming fills the whole window once; afterwards every DOWNSAMPLE words trigger a computation.
  assign w_wrap    = r_primed ? (r_acc_cnt == DS_LAST) : (r_acc_cnt == PRIME_LAST);
  assign w_capture = (r_state == S_WAIT) & (r_lat_cnt == LAT_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_primed     <= 1'b0;
      r_acc_cnt    <= '0;
      r_lat_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc_cnt <= w_wrap ? '0 : r_acc_cnt + 1'b1;
          if (w_wrap) begin
            r_primed <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_lat_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_capture) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Capture never waits on out_ready: an unconsumed sample is overwritten and flagged.
      if (w_capture) begin
        r_out_sample <= mca_sample;
        r_out_valid  <= 1'b1;
        if (r_out_valid & ~out_ready) r_overrun <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
